// File: rtl/ahbl_burst_master.sv
// AHB-Lite initiator: turns single-command requests into SINGLE/INCR4/8/16 bursts with
// pipelined address/data phases, BUSY insertion for late write data and error abort.
module ahbl_burst_master #(
  parameter int unsigned AHB_AWIDTH = 32,
  parameter int unsigned AHB_DWIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [AHB_AWIDTH-1:0] cmd_addr,
  input  logic [2:0]            cmd_size,
  input  logic [4:0]            cmd_beats,
  input  logic [AHB_DWIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [AHB_DWIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  done,
  output logic                  err,
  output logic [AHB_AWIDTH-1:0] HADDR,
  output logic [1:0]            HTRANS,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [AHB_DWIDTH-1:0] HWDATA,
  input  logic [AHB_DWIDTH-1:0] HRDATA,
  input  logic                  HREADY,
  input  logic                  HRESP
);

  localparam logic [1:0] TrIdle   = 2'b00;
  localparam logic [1:0] TrBusy   = 2'b01;
  localparam logic [1:0] TrNonseq = 2'b10;
  localparam logic [1:0] TrSeq    = 2'b11;

  typedef enum logic [2:0] {StIdle, StAddr, StBurst, StLast, StErr1, StErr2} state_e;

  state_e                  state_q, state_d;
  logic [AHB_AWIDTH-1:0]   addr_q;
  logic                    write_q;
  logic [2:0]              size_q;
  logic [2:0]              burst_q;
  logic [4:0]              beats_q;
  logic [4:0]              a_cnt_q;
  logic [4:0]              d_cnt_q;
  logic                    dphase_q;
  logic [AHB_DWIDTH-1:0]   wbuf_q;
  logic                    wbuf_full_q;
  logic [AHB_DWIDTH-1:0]   hwdata_q;
  logic [AHB_DWIDTH-1:0]   rd_data_q;
  logic                    rd_valid_q;
  logic                    done_q;
  logic                    err_q;

  logic        beats_ok, size_ok, align_ok, cross_1k, cmd_legal;
  logic [10:0] span;
  logic [2:0]  burst_enc;
  logic        beat_held, xfer, err_first, data_ok, last_addr, last_data;

  always_comb begin
    beats_ok  = 1'b1;
    burst_enc = 3'b000;
    case (cmd_beats)
      5'd1:    burst_enc = 3'b000;
      5'd4:    burst_enc = 3'b011;
      5'd8:    burst_enc = 3'b101;
      5'd16:   burst_enc = 3'b111;
      default: beats_ok  = 1'b0;
    endcase
    size_ok  = (cmd_size <= 3'd2);
    align_ok = !((cmd_size == 3'd1 && cmd_addr[0]) ||
                 (cmd_size == 3'd2 && cmd_addr[1:0] != 2'b00));
    // Last byte of the burst must stay inside the same 1KB page.
    span      = {1'b0, cmd_addr[9:0]} + (11'(cmd_beats) << cmd_size[1:0]);
    cross_1k  = (span > 11'd1024);
    cmd_legal = beats_ok && size_ok && align_ok && !cross_1k;
  end

  // Output / handshake decode
  always_comb begin
    cmd_ready = (state_q == StIdle);
    wr_ready  = ((state_q == StAddr) || (state_q == StBurst)) && !wbuf_full_q;
    // A write beat arriving this cycle is bypassed straight into the address phase.
    beat_held = !write_q || wbuf_full_q || (wr_valid && wr_ready);
    HTRANS    = TrIdle;
    case (state_q)
      StAddr:  HTRANS = beat_held ? TrNonseq : TrIdle;
      StBurst: HTRANS = beat_held ? TrSeq : TrBusy;
      default: HTRANS = TrIdle;
    endcase
  end

  assign xfer      = HREADY && HTRANS[1];
  assign err_first = dphase_q && HRESP && !HREADY;
  assign data_ok   = HREADY && dphase_q && !HRESP;
  assign last_addr = ((a_cnt_q + 5'd1) == beats_q);
  assign last_data = (d_cnt_q == (beats_q - 5'd1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (cmd_valid) state_d = cmd_legal ? StAddr : StErr2;
      StAddr, StBurst: begin
        if (err_first)  state_d = StErr1;
        else if (xfer)  state_d = last_addr ? StLast : StBurst;
      end
      StLast: begin
        if (err_first)                  state_d = StErr1;
        else if (data_ok && last_data)  state_d = StIdle;
      end
      StErr1:  if (HREADY) state_d = StErr2;
      StErr2:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      addr_q      <= '0;
      write_q     <= 1'b0;
      size_q      <= 3'b000;
      burst_q     <= 3'b000;
      beats_q     <= 5'd0;
      a_cnt_q     <= 5'd0;
      d_cnt_q     <= 5'd0;
      dphase_q    <= 1'b0;
      wbuf_q      <= '0;
      wbuf_full_q <= 1'b0;
      hwdata_q    <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      if (state_q == StIdle && cmd_valid) begin
        if (cmd_legal) begin
          addr_q  <= cmd_addr;
          write_q <= cmd_write;
          size_q  <= cmd_size;
          burst_q <= burst_enc;
          beats_q <= cmd_beats;
          a_cnt_q <= 5'd0;
          d_cnt_q <= 5'd0;
        end else begin
          done_q <= 1'b1;
          err_q  <= 1'b1;
        end
      end
      if (HREADY) dphase_q <= xfer;
      if (data_ok) begin
        d_cnt_q <= d_cnt_q + 5'd1;
        if (!write_q) begin
          rd_valid_q <= 1'b1;
          rd_data_q  <= HRDATA;
        end
      end
      if (xfer) begin
        addr_q  <= addr_q + (AHB_AWIDTH'(1) << size_q);
        a_cnt_q <= a_cnt_q + 5'd1;
        if (write_q) begin
          hwdata_q    <= wbuf_full_q ? wbuf_q : wr_data;
          wbuf_full_q <= 1'b0;
        end
      end else if (wr_valid && wr_ready) begin
        wbuf_q      <= wr_data;
        wbuf_full_q <= 1'b1;
      end
      if (state_q == StLast && data_ok && last_data) done_q <= 1'b1;
      if (state_q == StErr1) begin
        wbuf_full_q <= 1'b0;
        if (HREADY) begin
          done_q <= 1'b1;
          err_q  <= 1'b1;
        end
      end
    end
  end

  assign HADDR    = addr_q;
  assign HWRITE   = write_q;
  assign HSIZE    = size_q;
  assign HBURST   = burst_q;
  assign HWDATA   = hwdata_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_ahbl_burst_master.sv
// Directed bench for ahbl_burst_master: bursts, BUSY insertion, wait states, error
// abort, illegal commands and mid-burst reset.
module tb_ahbl_burst_master;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [2:0]  cmd_size;
  logic [4:0]  cmd_beats;
  logic [31:0] wr_data;
  logic        wr_valid, wr_ready;
  logic [31:0] rd_data;
  logic        rd_valid, done, err;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE, HBURST;
  logic [31:0] HWDATA, HRDATA;
  logic        HREADY, HRESP;

  int checks = 0;
  int errors = 0;

  // Test 2 per-cycle table: wr_valid, expected HTRANS, HADDR, HWDATA beat index (-1 = none)
  bit         t2_wv [11] = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 0};
  logic [1:0] t2_t  [11] = '{2'd2, 2'd3, 2'd3, 2'd1, 2'd1, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0};
  int         t2_a  [11] = '{'h100, 'h104, 'h108, 'h10C, 'h10C, 'h10C, 'h110, 'h114, 'h118,
                             'h11C, 0};
  int         t2_hw [11] = '{-1, 0, 1, 2, -1, -1, 3, 4, 5, 6, 7};

  // Illegal command vectors: addr, size, beats
  int         bad_a [4] = '{'h3F8, 'h100, 'h102, 'h100};
  int         bad_s [4] = '{2, 2, 2, 3};
  int         bad_b [4] = '{4, 3, 4, 1};

  always #5 HCLK = ~HCLK;

  ahbl_burst_master #(.AHB_AWIDTH(32), .AHB_DWIDTH(32)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_beats(cmd_beats),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge HCLK);
    #1;
  endtask

  task automatic smp();
    @(negedge HCLK);
  endtask

  task automatic cmd(input logic w, input logic [31:0] a, input logic [2:0] s,
                     input logic [4:0] b);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_size  = s;
    cmd_beats = b;
  endtask

  initial begin
    int k;
    int rv;
    HRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_size = '0;
    cmd_beats = '0; wr_data = '0; wr_valid = 1'b0; HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
    nxt(); nxt(); smp();
    check("rst_htrans", 32'(HTRANS), 0);
    check("rst_haddr", HADDR, 0);
    check("rst_hburst", 32'(HBURST), 0);
    check("rst_hwdata", HWDATA, 0);
    check("rst_cmd_ready", 32'(cmd_ready), 1);
    check("rst_wr_ready", 32'(wr_ready), 0);
    check("rst_flags", {29'd0, rd_valid, done, err}, 0);
    nxt(); HRESET = 1'b0;

    // Test 1: read INCR4 at 0x100, zero wait
    cmd(1'b0, 32'h100, 3'd2, 5'd4); smp();
    check("t1_ready", 32'(cmd_ready), 1);
    for (int i = 0; i < 6; i++) begin
      nxt(); cmd_valid = 1'b0; HRDATA = 32'hA000_0000 + 32'(i); smp();
      if (i < 4) begin
        check("t1_htrans", 32'(HTRANS), (i == 0) ? 32'd2 : 32'd3);
        check("t1_haddr", HADDR, 32'h100 + 32'(4 * i));
      end else check("t1_htrans_idle", 32'(HTRANS), 0);
      if (i == 0) check("t1_hburst", 32'(HBURST), 3);
      if (i >= 2) begin
        check("t1_rd_valid", 32'(rd_valid), 1);
        check("t1_rd_data", rd_data, 32'hA000_0000 + 32'(i - 1));
      end else check("t1_rd_valid0", 32'(rd_valid), 0);
      check("t1_done", 32'(done), (i == 5) ? 32'd1 : 32'd0);
    end
    check("t1_err", 32'(err), 0);

    // Test 2: write INCR8 with two late beats before beat 3
    nxt(); cmd(1'b1, 32'h100, 3'd2, 5'd8); smp();
    check("t2_ready", 32'(cmd_ready), 1);
    k = 0;
    for (int i = 0; i < 11; i++) begin
      nxt(); cmd_valid = 1'b0; wr_valid = t2_wv[i]; wr_data = 32'hD000_0000 + 32'(k); smp();
      check("t2_htrans", 32'(HTRANS), 32'(t2_t[i]));
      if (t2_t[i] != 2'd0) check("t2_haddr", HADDR, 32'(t2_a[i]));
      if (t2_hw[i] >= 0) check("t2_hwdata", HWDATA, 32'hD000_0000 + 32'(t2_hw[i]));
      check("t2_wr_ready", 32'(wr_ready), (i < 10) ? 32'd1 : 32'd0);
      if (i == 0) check("t2_hburst_hwrite", {28'd0, HBURST, HWRITE}, 32'hB);
      if (t2_wv[i]) k++;
    end
    nxt(); wr_valid = 1'b0; smp();
    check("t2_done", {30'd0, done, err}, 2);

    // Test 3: write SINGLE with three wait states
    nxt(); cmd(1'b1, 32'h200, 3'd2, 5'd1); smp();
    nxt(); cmd_valid = 1'b0; wr_valid = 1'b1; wr_data = 32'hCAFE_0001; smp();
    check("t3_nonseq", 32'(HTRANS), 2);
    check("t3_haddr", HADDR, 32'h200);
    check("t3_hburst", 32'(HBURST), 0);
    for (int i = 0; i < 3; i++) begin
      nxt(); wr_valid = 1'b0; wr_data = 32'hBAD0_0000; HREADY = 1'b0; smp();
      check("t3_stall_htrans", 32'(HTRANS), 0);
      check("t3_stall_hwdata", HWDATA, 32'hCAFE_0001);
      check("t3_stall_done", 32'(done), 0);
    end
    nxt(); HREADY = 1'b1; smp();
    check("t3_hwdata_final", HWDATA, 32'hCAFE_0001);
    nxt(); smp();
    check("t3_done", {30'd0, done, err}, 2);
    check("t3_idle", 32'(HTRANS), 0);

    // Test 4: read INCR16, ERROR on data phase of beat index 5
    nxt(); cmd(1'b0, 32'h40, 3'd2, 5'd16); smp();
    rv = 0;
    for (int i = 1; i <= 10; i++) begin
      nxt(); cmd_valid = 1'b0; HREADY = (i != 7); HRESP = (i == 7 || i == 8);
      HRDATA = 32'hB000_0000 + 32'(i); smp();
      if (rd_valid) rv++;
      if (i == 6) check("t4_rd_data", rd_data, 32'hB000_0005);
      if (i == 7) begin
        check("t4_seq_at_err", 32'(HTRANS), 3);
        check("t4_haddr_at_err", HADDR, 32'h58);
      end
      if (i == 8) check("t4_idle_after_err", 32'(HTRANS), 0);
      if (i == 9) begin
        check("t4_no_rd_valid_err_beat", 32'(rd_valid), 0);
        check("t4_done_err", {30'd0, done, err}, 3);
      end
      if (i == 10) check("t4_cmd_ready", 32'(cmd_ready), 1);
    end
    check("t4_rd_valid_count", 32'(rv), 5);

    // Test 5: illegal commands rejected without bus activity
    for (int v = 0; v < 4; v++) begin
      nxt(); cmd(1'b0, 32'(bad_a[v]), 3'(bad_s[v]), 5'(bad_b[v])); smp();
      check("t5_ready", 32'(cmd_ready), 1);
      nxt(); cmd_valid = 1'b0; smp();
      check("t5_done_err", {30'd0, done, err}, 3);
      check("t5_htrans", 32'(HTRANS), 0);
      nxt(); smp();
      check("t5_quiet", {29'd0, HTRANS, done}, 0);
    end
    // Exactly reaches the 1KB boundary: legal
    nxt(); cmd(1'b0, 32'h3F0, 3'd2, 5'd4); smp();
    for (int i = 0; i < 6; i++) begin
      nxt(); cmd_valid = 1'b0; smp();
      if (i < 4) begin
        check("t5b_htrans", 32'(HTRANS), (i == 0) ? 32'd2 : 32'd3);
        check("t5b_haddr", HADDR, 32'h3F0 + 32'(4 * i));
      end
      if (i == 5) check("t5b_done", {30'd0, done, err}, 2);
    end

    // Test 6: reset mid-burst, then a fresh read SINGLE
    nxt(); cmd(1'b0, 32'h0, 3'd2, 5'd8); smp();
    nxt(); cmd_valid = 1'b0; smp();
    check("t6_nonseq", 32'(HTRANS), 2);
    nxt(); smp();
    check("t6_seq", 32'(HTRANS), 3);
    nxt(); HRESET = 1'b1; smp();
    nxt(); HRESET = 1'b0; cmd(1'b0, 32'h80, 3'd2, 5'd1); smp();
    check("t6_rst_htrans", 32'(HTRANS), 0);
    check("t6_rst_haddr", HADDR, 0);
    check("t6_rst_ready", 32'(cmd_ready), 1);
    check("t6_rst_flags", {29'd0, rd_valid, done, err}, 0);
    nxt(); cmd_valid = 1'b0; smp();
    check("t6_single_nonseq", 32'(HTRANS), 2);
    check("t6_single_haddr", HADDR, 32'h80);
    check("t6_single_hburst", 32'(HBURST), 0);
    nxt(); HRDATA = 32'h0000_5A5A; smp();
    check("t6_dphase_idle", {29'd0, HTRANS, done}, 0);
    nxt(); smp();
    check("t6_rd_valid", 32'(rd_valid), 1);
    check("t6_rd_data", rd_data, 32'h0000_5A5A);
    check("t6_done", {30'd0, done, err}, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
